x3q_fetch_unit: RTL and testbench
=================================

Name: x3q_fetch_unit

Overview:
Parametrised instruction-fetch/prefetch block for the next-generation x3q core. It issues read requests on the shared single-port memory handshake and buffers returned instruction words with their addresses in a DEPTH-entry FIFO, so decode no longer waits on memory latency. It also handles control-flow redirects: the FIFO is flushed and any in-flight read response is discarded. It sits between the memory arbiter and the core's decode/execute sequencer.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 16, word-address width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_ADDR, 0, fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fetch_en  in  1  allows new memory requests when high
memory_in  in  DATA_W  read data from memory
memory_ready  in  1  read data valid this cycle
request  out  1  one-cycle read request pulse
request_address  out  ADDR_W  address for request; held until response
redirect  in  1  flush FIFO and restart fetch at redirect_addr
redirect_addr  in  ADDR_W  new fetch address
instr_take  in  1  consumer pops FIFO head
instr_valid  out  1  FIFO non-empty
instr_data  out  DATA_W  FIFO head instruction
instr_addr  out  ADDR_W  FIFO head address
fifo_count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All registers update on posedge clk.
- Reset values: pc=RESET_ADDR, request_address=RESET_ADDR, request=0, FIFO empty, fifo_count=0, instr_valid=0, instr_data=0, instr_addr=0, state=IDLE.
- Reset mid-operation: any outstanding response is forgotten. The first request after reset uses RESET_ADDR.
- instr_valid, instr_data and instr_addr are combinational from the FIFO head (registered storage). When empty, instr_data and instr_addr read as 0.
- At most one outstanding read at a time.
- FSM state IDLE:
  - If fetch_en && !redirect && fifo_count<DEPTH: request=1 for one cycle, request_address=pc, state goes to WAIT.
  - If redirect: pc=redirect_addr, stay IDLE. The request may fire the following cycle.
- FSM state WAIT:
  - On memory_ready: push {pc, memory_in}, pc=pc+1 modulo 2^ADDR_W, go to IDLE.
  - Next request is issued no earlier than the cycle after the response.
  - memory_ready in IDLE is ignored.
- FSM state DISCARD: waits for the stale response.
  - On memory_ready: drop the data, go to IDLE.
  - The pc was already updated by the redirect.
- Redirect in WAIT:
  - FIFO is flushed and pc=redirect_addr.
  - If memory_ready arrives in the same cycle, the data is dropped and the state goes to IDLE.
  - Otherwise the state goes to DISCARD.
- Redirect in DISCARD: pc=redirect_addr, stay in DISCARD.
- Redirect has priority over instr_take and over a push in the same cycle. After the flush, fifo_count=0 on the next cycle.
- Push and instr_take in the same cycle: fifo_count unchanged. Head advances; the new entry is appended.
- instr_take when empty: ignored, no underflow.
- A push can only occur when a slot was reserved at request time, so there is never an overflow. The request condition is fifo_count<DEPTH; only one request is in flight.
- Read/write pointers are log2(DEPTH) bits and wrap naturally.
- fetch_en=0 in WAIT does not cancel the outstanding read; it only blocks new requests.
- Latency:
  - request issues 1 cycle after entering IDLE with space available.
  - Data is visible on instr_valid the cycle after memory_ready.

Test Plan:
- Cold start: deassert reset, fetch_en=1, memory returns mem[a]=0x1000+a after 2 cycles -> request at addr 0,1,2,3. Head shows instr_addr=0, instr_data=0x1000. fifo_count reaches 4 with no take, then requests stop.
- Full then drain: FIFO full, pulse instr_take once -> fifo_count 4->3, next request at address 4, entry {4,0x1004} appended in order.
- Redirect mid-flight: redirect=1 with redirect_addr=0x0200 while WAIT, memory_ready 2 cycles later -> response dropped, FIFO empty. Next request address is 0x0200, and the head becomes {0x0200, mem[0x0200]}.
- Redirect coincident with memory_ready and instr_take -> nothing pushed, fifo_count=0 next cycle, next request at redirect_addr.
- Wrap-around: redirect_addr=0xFFFF -> entries {0xFFFF,...} then {0x0000,...}. Simultaneous take and push keeps fifo_count constant.
- Reset mid-WAIT: assert reset for one cycle while a request is outstanding, late memory_ready arrives -> ignored. request_address=RESET_ADDR, fifo_count=0, first new request at RESET_ADDR.

Source files
------------

// File: rtl/x3q_fetch_unit.sv
// x3q_fetch_unit: instruction prefetch with a DEPTH-entry FIFO and redirect flush.
// Ports: clk/reset; memory handshake (request, request_address, memory_in,
//   memory_ready); control (fetch_en, redirect, redirect_addr); decode side
//   (instr_take, instr_valid, instr_data, instr_addr, fifo_count).
module x3q_fetch_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic [DATA_W-1:0] memory_in,
   input  logic              memory_ready,
   output logic              request,
   output logic [ADDR_W-1:0] request_address,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              instr_take,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_addr,
   output logic [CW-1:0]     fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic              request_q;

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic push;
   logic pop;

   // A redirect overrides both the push and the pop of this cycle.
   assign push = (state_q == S_WAIT) && memory_ready && !redirect;
   assign pop  = instr_take && (count_q != '0) && !redirect;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop) count_d = count_q + CW'(1);
         if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr_q] <= memory_in;
         addr_q[wr_ptr_q] <= pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_ADDR;
         req_addr_q <= RESET_ADDR;
         request_q  <= 1'b0;
      end else begin
         request_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (redirect) begin
                  pc_q <= redirect_addr;
               end else if (fetch_en && count_q < FULL) begin
                  // Slot is reserved now; only takes or a flush follow.
                  request_q  <= 1'b1;
                  req_addr_q <= pc_q;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect) begin
                  pc_q    <= redirect_addr;
                  state_q <= memory_ready ? S_IDLE : S_DISCARD;
               end else if (memory_ready) begin
                  pc_q    <= pc_q + ADDR_W'(1);
                  state_q <= S_IDLE;
               end
            end
            S_DISCARD: begin
               if (redirect) pc_q <= redirect_addr;
               if (memory_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign request         = request_q;
   assign request_address = req_addr_q;
   assign fifo_count      = count_q;
   assign instr_valid     = (count_q != '0);
   assign instr_data      = instr_valid ? data_q[rd_ptr_q] : '0;
   assign instr_addr      = instr_valid ? addr_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_x3q_fetch_unit.sv
// tb_x3q_fetch_unit: directed cycle-by-cycle vectors for x3q_fetch_unit.
// Ports: none (drives clock, reset and memory responses itself).
module tb_x3q_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [15:0] memory_in;
   logic        memory_ready;
   logic        request;
   logic [15:0] request_address;
   logic        redirect;
   logic [15:0] redirect_addr;
   logic        instr_take;
   logic        instr_valid;
   logic [15:0] instr_data;
   logic [15:0] instr_addr;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   x3q_fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_en        (fetch_en),
      .memory_in       (memory_in),
      .memory_ready    (memory_ready),
      .request         (request),
      .request_address (request_address),
      .redirect        (redirect),
      .redirect_addr   (redirect_addr),
      .instr_take      (instr_take),
      .instr_valid     (instr_valid),
      .instr_data      (instr_data),
      .instr_addr      (instr_addr),
      .fifo_count      (fifo_count)
   );

   typedef struct {
      logic        rst;
      logic        en;
      logic        mr;
      logic [15:0] din;
      logic        rd;
      logic [15:0] rda;
      logic        take;
      logic        req;
      logic [15:0] ra;
      logic        val;
      logic [15:0] dat;
      logic [15:0] adr;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vq[$];

   task automatic v(
      input logic rst, input logic en, input logic mr,
      input logic [15:0] din, input logic rd,
      input logic [15:0] rda, input logic take,
      input logic req, input logic [15:0] ra,
      input logic val, input logic [15:0] dat,
      input logic [15:0] adr, input logic [2:0] cnt);
      vec_t e;
      e.rst = rst; e.en = en; e.mr = mr; e.din = din;
      e.rd = rd; e.rda = rda; e.take = take;
      e.req = req; e.ra = ra; e.val = val;
      e.dat = dat; e.adr = adr; e.cnt = cnt;
      vq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm,
      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic en,
      input logic mr, input logic [15:0] din, input logic rd,
      input logic [15:0] rda, input logic take);
      reset = rst; fetch_en = en; memory_ready = mr;
      memory_in = din; redirect = rd;
      redirect_addr = rda; instr_take = take;
   endtask

   task automatic outs(input string nm, input logic req,
      input logic [15:0] ra, input logic val,
      input logic [15:0] dat, input logic [15:0] adr,
      input logic [2:0] cnt);
      chk({nm, " request"}, 32'(request), 32'(req));
      chk({nm, " req_addr"}, 32'(request_address), 32'(ra));
      chk({nm, " valid"}, 32'(instr_valid), 32'(val));
      chk({nm, " data"}, 32'(instr_data), 32'(dat));
      chk({nm, " addr"}, 32'(instr_addr), 32'(adr));
      chk({nm, " count"}, 32'(fifo_count), 32'(cnt));
   endtask

   initial begin
      // rst en mr din rd rda take | req ra val dat adr cnt
      v(1,0,0,16'h0,0,16'h0,0, 0,16'h0000,0,16'h0000,16'h0000,0);
      v(1,1,0,16'h0,0,16'h0,0, 0,16'h0000,0,16'h0000,16'h0000,0);
      // cold start, responses two cycles after request
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0000,0,16'h0000,16'h0000,0);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0000,0,16'h0000,16'h0000,0);
      v(0,1,1,16'h1000,0,16'h0,0, 0,16'h0000,1,16'h1000,16'h0000,1);
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0001,1,16'h1000,16'h0000,1);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0001,1,16'h1000,16'h0000,1);
      v(0,1,1,16'h1001,0,16'h0,0, 0,16'h0001,1,16'h1000,16'h0000,2);
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0002,1,16'h1000,16'h0000,2);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0002,1,16'h1000,16'h0000,2);
      v(0,1,1,16'h1002,0,16'h0,0, 0,16'h0002,1,16'h1000,16'h0000,3);
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0003,1,16'h1000,16'h0000,3);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0003,1,16'h1000,16'h0000,3);
      v(0,1,1,16'h1003,0,16'h0,0, 0,16'h0003,1,16'h1000,16'h0000,4);
      // full: requests stop
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0003,1,16'h1000,16'h0000,4);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0003,1,16'h1000,16'h0000,4);
      // one take, then request at 4 and append
      v(0,1,0,16'h0,0,16'h0,1, 0,16'h0003,1,16'h1001,16'h0001,3);
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0004,1,16'h1001,16'h0001,3);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0004,1,16'h1001,16'h0001,3);
      v(0,1,1,16'h1004,0,16'h0,0, 0,16'h0004,1,16'h1001,16'h0001,4);
      // drain in order, then take on empty
      v(0,1,0,16'h0,0,16'h0,1, 0,16'h0004,1,16'h1002,16'h0002,3);
      v(0,1,0,16'h0,0,16'h0,1, 1,16'h0005,1,16'h1003,16'h0003,2);
      v(0,0,0,16'h0,0,16'h0,1, 0,16'h0005,1,16'h1004,16'h0004,1);
      v(0,0,0,16'h0,0,16'h0,1, 0,16'h0005,0,16'h0000,16'h0000,0);
      v(0,0,0,16'h0,0,16'h0,1, 0,16'h0005,0,16'h0000,16'h0000,0);
      // redirect while waiting; late response dropped
      v(0,1,0,16'h0,1,16'h0200,0, 0,16'h0005,0,16'h0000,16'h0000,0);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0005,0,16'h0000,16'h0000,0);
      v(0,1,1,16'hDEAD,0,16'h0,0, 0,16'h0005,0,16'h0000,16'h0000,0);
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0200,0,16'h0000,16'h0000,0);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0200,0,16'h0000,16'h0000,0);
      v(0,1,1,16'h1200,0,16'h0,0, 0,16'h0200,1,16'h1200,16'h0200,1);
      // redirect + ready + take together
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0201,1,16'h1200,16'h0200,1);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0201,1,16'h1200,16'h0200,1);
      v(0,1,1,16'h1201,1,16'hFFFF,1, 0,16'h0201,0,16'h0000,16'h0000,0);
      // wrap-around and simultaneous push/take
      v(0,1,0,16'h0,0,16'h0,0, 1,16'hFFFF,0,16'h0000,16'h0000,0);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'hFFFF,0,16'h0000,16'h0000,0);
      v(0,1,1,16'h0FFF,0,16'h0,0, 0,16'hFFFF,1,16'h0FFF,16'hFFFF,1);
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0000,1,16'h0FFF,16'hFFFF,1);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0000,1,16'h0FFF,16'hFFFF,1);
      v(0,1,1,16'h1000,0,16'h0,1, 0,16'h0000,1,16'h1000,16'h0000,1);
      // reset while a read is outstanding
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0001,1,16'h1000,16'h0000,1);
      v(1,1,0,16'h0,0,16'h0,0, 0,16'h0000,0,16'h0000,16'h0000,0);
      v(0,0,1,16'hBEEF,0,16'h0,0, 0,16'h0000,0,16'h0000,16'h0000,0);
      v(0,1,0,16'h0,0,16'h0,0, 1,16'h0000,0,16'h0000,16'h0000,0);
      v(0,1,0,16'h0,0,16'h0,0, 0,16'h0000,0,16'h0000,16'h0000,0);
      v(0,1,1,16'h1000,0,16'h0,0, 0,16'h0000,1,16'h1000,16'h0000,1);

      drive(1, 0, 0, 16'h0, 0, 16'h0, 0);
      #2;
      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].en, vq[i].mr, vq[i].din,
               vq[i].rd, vq[i].rda, vq[i].take);
         step();
         outs($sformatf("v%0d", i), vq[i].req, vq[i].ra,
              vq[i].val, vq[i].dat, vq[i].adr, vq[i].cnt);
      end

      // redirect while discarding keeps the newest target
      drive(0, 1, 0, 16'h0, 0, 16'h0, 0);
      step(); outs("h1", 1, 16'h0001, 1, 16'h1000, 16'h0000, 1);
      step(); outs("h2", 0, 16'h0001, 1, 16'h1000, 16'h0000, 1);
      drive(0, 1, 0, 16'h0, 1, 16'h0300, 0);
      step(); outs("h3", 0, 16'h0001, 0, 16'h0000, 16'h0000, 0);
      drive(0, 1, 0, 16'h0, 1, 16'h0400, 0);
      step(); outs("h4", 0, 16'h0001, 0, 16'h0000, 16'h0000, 0);
      drive(0, 1, 1, 16'h5555, 0, 16'h0, 0);
      step(); outs("h5", 0, 16'h0001, 0, 16'h0000, 16'h0000, 0);
      drive(0, 1, 0, 16'h0, 0, 16'h0, 0);
      step(); outs("h6", 1, 16'h0400, 0, 16'h0000, 16'h0000, 0);
      step(); outs("h7", 0, 16'h0400, 0, 16'h0000, 16'h0000, 0);
      drive(0, 1, 1, 16'h1400, 0, 16'h0, 0);
      step(); outs("h8", 0, 16'h0400, 1, 16'h1400, 16'h0400, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
